// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the serial ADC front end.
//   - ADC_W / BIT_CNT_W: conversion word and bit counter widths
//   - adc_state_e: sampler FSM state encoding
//   - min_period / eff_period: shortest legal conversion-to-conversion spacing
package adc_pkg;

    localparam int unsigned ADC_W     = 16;
    localparam int unsigned BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StShift,
        StDeselect,
        StDone
    } adc_state_e;

    // A full conversion occupies 34*clk_div+2 cycles including the valid cycle.
    function automatic int unsigned min_period(input int unsigned clk_div);
        return 34 * clk_div + 2;
    endfunction

    function automatic int unsigned eff_period(input int unsigned clk_div,
                                               input int unsigned period);
        return (period < min_period(clk_div)) ? min_period(clk_div) : period;
    endfunction

endpackage

// File: rtl/adc_sampler_sclk_tick_gen.sv
// sclk_tick_gen: divides the system clock into SCLK half-period ticks.
//   clk   system clock
//   rst   asynchronous active-high reset
//   en    count enable; counter is held at zero while low
//   tick  one-cycle pulse in the last cycle of each CLK_DIV-cycle half-period
module sclk_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign tick = en && (cnt == CNT_MAX);

    always_comb begin
        cnt_next = cnt;
        if (!en || tick) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: 3-wire serial ADC front end producing a parallel 16-bit result.
//   clk        system clock
//   rst        asynchronous active-high reset
//   enable     periodic conversion mode enable
//   start      one-shot conversion request (ignored while busy)
//   adc_miso   serial data from the ADC, sampled as SCLK rises, MSB first
//   adc_cs_n   ADC chip select, active low
//   adc_sclk   ADC serial clock, idles low
//   adc_data   last completed conversion result
//   adc_valid  one-cycle pulse when adc_data updates
//   busy       high from conversion start through the adc_valid cycle
module adc_sampler
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             start,
    input  logic             adc_miso,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic [ADC_W-1:0] adc_data,
    output logic             adc_valid,
    output logic             busy
);

    localparam int unsigned PERIOD = eff_period(CLK_DIV, SAMPLE_PERIOD);
    localparam int unsigned PCNT_W = $clog2(PERIOD);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PERIOD - 1);
    localparam logic [BIT_CNT_W-1:0] BITS_ALL = BIT_CNT_W'(ADC_W);

    adc_state_e           state, state_next;
    logic                 cs_n_next;
    logic                 sclk_next;
    logic [ADC_W-1:0]     data_next;
    logic                 valid_next;
    logic                 busy_next;
    logic [ADC_W-1:0]     shift_reg, shift_next;
    logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [PCNT_W-1:0]    period_cnt, period_next;

    logic tick_en;
    logic tick;
    logic period_hit;
    logic trigger;

    assign tick_en = (state == StSelect) || (state == StShift) || (state == StDeselect);

    sclk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .tick(tick)
    );

    // The periodic trigger is not gated by busy: the clamped period guarantees
    // it only lands once the previous valid cycle has passed.
    assign period_hit = enable && (period_cnt == PCNT_MAX);
    assign trigger    = (start && !busy) || period_hit;

    always_comb begin
        state_next   = state;
        cs_n_next    = adc_cs_n;
        sclk_next    = adc_sclk;
        data_next    = adc_data;
        valid_next   = 1'b0;
        busy_next    = busy;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;

        unique case (state)
            StIdle: begin
                busy_next = 1'b0;
                if (trigger) begin
                    state_next   = StSelect;
                    cs_n_next    = 1'b0;
                    busy_next    = 1'b1;
                    shift_next   = '0;
                    bit_cnt_next = '0;
                end
            end
            StSelect: begin
                if (tick) begin
                    state_next = StShift;
                end
            end
            StShift: begin
                if (tick) begin
                    if (!adc_sclk) begin
                        // Capture on the edge that raises SCLK; data is stable
                        // since the ADC drove it on the previous falling edge.
                        sclk_next    = 1'b1;
                        shift_next   = {shift_reg[ADC_W-2:0], adc_miso};
                        bit_cnt_next = bit_cnt + 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt == BITS_ALL) begin
                            state_next = StDeselect;
                            cs_n_next  = 1'b1;
                        end
                    end
                end
            end
            StDeselect: begin
                if (tick) begin
                    state_next = StDone;
                end
            end
            StDone: begin
                data_next  = shift_reg;
                valid_next = 1'b1;
                state_next = StIdle;
            end
            default: begin
                state_next = StIdle;
                cs_n_next  = 1'b1;
                sclk_next  = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        period_next = period_cnt;
        if (!enable) begin
            period_next = '0;
        end else if ((state == StIdle && trigger) || period_cnt == PCNT_MAX) begin
            period_next = '0;
        end else begin
            period_next = period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            adc_data   <= '0;
            adc_valid  <= 1'b0;
            busy       <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            period_cnt <= '0;
        end else begin
            state      <= state_next;
            adc_cs_n   <= cs_n_next;
            adc_sclk   <= sclk_next;
            adc_data   <= data_next;
            adc_valid  <= valid_next;
            busy       <= busy_next;
            shift_reg  <= shift_next;
            bit_cnt    <= bit_cnt_next;
            period_cnt <= period_next;
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
module tb_adc_sampler;

    localparam int unsigned CLK_DIV       = 4;
    localparam int unsigned SAMPLE_PERIOD = 200;
    localparam int          LATENCY       = 34 * CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        adc_miso;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        busy;

    int checks = 0;
    int passed = 0;

    adc_sampler #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .start    (start),
        .adc_miso (adc_miso),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: MSB on chip-select fall, next bit on each SCLK fall.
    logic [15:0] model_q[$];
    logic [15:0] cur_word = 16'h0;
    logic [3:0]  bit_idx = 4'd15;
    bit          xfer_on = 1'b0;
    assign adc_miso = cur_word[bit_idx];

    always @(negedge adc_cs_n or posedge adc_cs_n or negedge adc_sclk) begin
        if (adc_cs_n) begin
            xfer_on = 1'b0;
        end else if (!xfer_on) begin
            xfer_on = 1'b1;
            bit_idx = 4'd15;
            cur_word = (model_q.size() > 0) ? model_q.pop_front() : 16'h0;
        end else if (bit_idx > 0) begin
            bit_idx = bit_idx - 4'd1;
        end
    end

    int rise_cnt = 0;
    always @(posedge adc_sclk) if (!adc_cs_n) rise_cnt++;

    // Monitor samples 2 time units after each rising clock edge.
    int          valid_cnt = 0;
    int          valid_cyc[$];
    logic [15:0] valid_dat[$];
    int          first_rise = -1;
    int          cs_rise = -1;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    always @(posedge clk) begin
        #2;
        if (adc_sclk && !prev_sclk && first_rise < 0) first_rise = cyc;
        if (adc_cs_n && !prev_cs) cs_rise = cyc;
        if (adc_valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            valid_dat.push_back(adc_data);
        end
        prev_sclk = adc_sclk;
        prev_cs   = adc_cs_n;
    end

    logic [15:0] exp_q[$];

    task automatic clear_log();
        valid_cnt = 0;
        valid_cyc.delete();
        valid_dat.delete();
        first_rise = -1;
        cs_rise = -1;
        rise_cnt = 0;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_valids(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (valid_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (adc_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n);
        else passed++;
        checks++;
        if (adc_sclk !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", adc_sclk);
        else passed++;
        checks++;
        if (adc_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", adc_data);
        else passed++;
        checks++;
        if (adc_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", adc_valid);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else passed++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (adc_cs_n !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset_idle: got cs_n=%b busy=%b expected 1/0", adc_cs_n, busy);
        else passed++;
    endtask

    task automatic test_one_shot();
        int t0;
        bit ok;
        logic [15:0] exp;
        clear_log();
        model_q.push_back(16'h3081);
        exp_q.push_back(16'h3081);
        pulse_start(t0);
        checks++;
        if (adc_cs_n !== 1'b0 || busy !== 1'b1)
            $display("FAIL oneshot_start: got cs_n=%b busy=%b expected 0/1", adc_cs_n, busy);
        else passed++;
        wait_valids(1, 300, ok);
        checks++;
        if (!ok) $display("FAIL oneshot_timeout: got no valid expected one");
        else passed++;
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (valid_dat[0] !== exp)
                $display("FAIL oneshot_data: got %h expected %h", valid_dat[0], exp);
            else passed++;
            checks++;
            if (valid_cyc[0] - t0 != LATENCY)
                $display("FAIL oneshot_latency: got %0d expected %0d", valid_cyc[0] - t0, LATENCY);
            else passed++;
        end
        checks++;
        if (rise_cnt != 16) $display("FAIL oneshot_rises: got %0d expected 16", rise_cnt);
        else passed++;
        checks++;
        if (first_rise - t0 != 2 * CLK_DIV)
            $display("FAIL first_rise: got %0d expected %0d", first_rise - t0, 2 * CLK_DIV);
        else passed++;
        checks++;
        if (cs_rise - t0 != 33 * CLK_DIV)
            $display("FAIL cs_rise: got %0d expected %0d", cs_rise - t0, 33 * CLK_DIV);
        else passed++;
        @(negedge clk);
        checks++;
        if (adc_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL oneshot_after: got valid=%b busy=%b expected 0/0", adc_valid, busy);
        else passed++;
        checks++;
        if (adc_data !== 16'h3081) $display("FAIL oneshot_hold: got %h expected 3081", adc_data);
        else passed++;
    endtask

    task automatic test_periodic();
        bit ok;
        logic [15:0] exp;
        clear_log();
        model_q.push_back(16'hFFFF);
        model_q.push_back(16'h0000);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        @(negedge clk);
        enable = 1'b1;
        wait_valids(2, 800, ok);
        enable = 1'b0;
        checks++;
        if (!ok) $display("FAIL periodic_timeout: got %0d valids expected 2", valid_cnt);
        else passed++;
        if (ok) begin
            checks++;
            if (valid_cyc[1] - valid_cyc[0] != SAMPLE_PERIOD)
                $display("FAIL periodic_spacing: got %0d expected %0d",
                         valid_cyc[1] - valid_cyc[0], SAMPLE_PERIOD);
            else passed++;
            for (int i = 0; i < 2; i++) begin
                exp = exp_q.pop_front();
                checks++;
                if (valid_dat[i] !== exp)
                    $display("FAIL periodic_data%0d: got %h expected %h", i, valid_dat[i], exp);
                else passed++;
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        int t0;
        int t1;
        bit ok;
        logic [15:0] exp;
        clear_log();
        model_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        pulse_start(t0);
        repeat (18) @(negedge clk);
        pulse_start(t1);
        wait_valids(1, 300, ok);
        repeat (300) @(negedge clk);
        checks++;
        if (valid_cnt != 1) $display("FAIL busy_valid_count: got %0d expected 1", valid_cnt);
        else passed++;
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (valid_dat[0] !== exp)
                $display("FAIL busy_data: got %h expected %h", valid_dat[0], exp);
            else passed++;
            checks++;
            if (valid_cyc[0] - t0 != LATENCY)
                $display("FAIL busy_latency: got %0d expected %0d", valid_cyc[0] - t0, LATENCY);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        bit hit;
        logic [15:0] exp;
        clear_log();
        model_q.push_back(16'hA5A5);
        model_q.push_back(16'hA5A5);
        exp_q.push_back(16'hA5A5);
        pulse_start(t0);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rise_cnt >= 8) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) $display("FAIL midreset_rises: got %0d expected 8", rise_cnt);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (adc_cs_n !== 1'b1 || adc_sclk !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset_async: got cs_n=%b sclk=%b busy=%b expected 1/0/0",
                     adc_cs_n, adc_sclk, busy);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        checks++;
        if (valid_cnt != 0) $display("FAIL midreset_novalid: got %0d expected 0", valid_cnt);
        else passed++;
        checks++;
        if (adc_data !== 16'h0000) $display("FAIL midreset_data: got %h expected 0000", adc_data);
        else passed++;
        clear_log();
        pulse_start(t0);
        wait_valids(1, 300, ok);
        checks++;
        if (!ok) $display("FAIL midreset_retry_timeout: got no valid expected one");
        else passed++;
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (valid_dat[0] !== exp)
                $display("FAIL midreset_retry_data: got %h expected %h", valid_dat[0], exp);
            else passed++;
        end
        checks++;
        if (rise_cnt != 16) $display("FAIL midreset_retry_rises: got %0d expected 16", rise_cnt);
        else passed++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit hit;
        logic [15:0] exp;
        clear_log();
        model_q.push_back(16'hBEEF);
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        enable = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (adc_sclk) begin
                hit = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        checks++;
        if (!hit) $display("FAIL drop_reach_shift: got sclk=%b expected 1", adc_sclk);
        else passed++;
        wait_valids(1, 300, ok);
        checks++;
        if (!ok) $display("FAIL drop_timeout: got no valid expected one");
        else passed++;
        if (ok) begin
            exp = exp_q.pop_front();
            checks++;
            if (valid_dat[0] !== exp)
                $display("FAIL drop_data: got %h expected %h", valid_dat[0], exp);
            else passed++;
        end
        repeat (500) @(negedge clk);
        checks++;
        if (valid_cnt != 1 || busy !== 1'b0 || adc_cs_n !== 1'b1)
            $display("FAIL drop_quiet: got valids=%0d busy=%b cs_n=%b expected 1/0/1",
                     valid_cnt, busy, adc_cs_n);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_busy_ignore();
        test_reset_mid();
        test_enable_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish within bound");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_sampler.md
# adc_sampler

Serial ADC front end for the smart-home temperature path. Drives a 3-wire SPI-style ADC (chip select, serial clock, data in), shifts in one 16-bit conversion result MSB-first, and presents it as a parallel `adc_data` word with a one-cycle valid strobe. It is the producer side of the `adc_data` input consumed by `TemperatureCalculator`. Conversions are triggered one-shot by `start` or run periodically while `enable` is high.

## Interface
- `CLK_DIV`, 4: system clocks per SCLK half-period; legal range ≥ 2.
- `SAMPLE_PERIOD`, 1000: system clocks between conversion starts in periodic mode; values below `34*CLK_DIV+2` are treated as `34*CLK_DIV+2`.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  periodic mode enable.
- `start`  input  1  one-shot conversion request, sampled on `clk` edges.
- `adc_miso`  input  1  serial data from ADC.
- `adc_cs_n`  output  1  ADC chip select, active low.
- `adc_sclk`  output  1  ADC serial clock, idles low.
- `adc_data`  output  16  last completed conversion result.
- `adc_valid`  output  1  one-cycle pulse when `adc_data` updates.
- `busy`  output  1  high from conversion start until the `adc_valid` cycle inclusive.

## Operation
- States: IDLE, SELECT, SHIFT, DESELECT, DONE.
- IDLE: `adc_cs_n`=1, `adc_sclk`=0. Leaves to SELECT when `start`=1, or when `enable`=1 and the period counter reaches `SAMPLE_PERIOD-1`.
- SELECT: `adc_cs_n`=0 for `CLK_DIV` cycles (setup), SCLK still low.
- SHIFT: 16 SCLK periods, each `CLK_DIV` low then `CLK_DIV` high. `adc_miso` is sampled in the cycle SCLK rises, shifted in MSB-first. After the 16th high phase, SCLK returns low and the FSM enters DESELECT.
- DESELECT: `adc_cs_n`=1, held `CLK_DIV` cycles (hold/quiet time).
- DONE: one cycle; `adc_data` loaded from shift register, `adc_valid`=1; then IDLE.
- Period counter: resets to 0 at every conversion start; free-runs only while `enable`=1; cleared when `enable`=0.
- `start` while `busy`=1 is ignored (not queued). `start` and periodic trigger in the same cycle start exactly one conversion.
- Deasserting `enable` mid-conversion does not abort; the conversion completes and `adc_valid` fires.
- `adc_data` holds its value between conversions; never changes except in DONE.

## Timing
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=16'h0000, `adc_valid`=0, `busy`=0, state IDLE, counters 0.
- `rst` asserted mid-conversion: outputs go to reset values immediately (asynchronous); partial shift data discarded; no `adc_valid`.
- All outputs registered; no combinational path from inputs to outputs.
- Trigger sampled at edge T0 → `adc_cs_n` low and `busy` high after T0; first SCLK rise `2*CLK_DIV` cycles after T0; `adc_cs_n` high `33*CLK_DIV` cycles after T0; `adc_valid` high in the cycle starting `34*CLK_DIV+1` cycles after T0 (137 at `CLK_DIV`=4).
- Periodic mode: consecutive `adc_valid` pulses are exactly `SAMPLE_PERIOD` cycles apart.
- Shift register width 16; bit counter 5 bits; divider counter `$clog2(CLK_DIV)` bits; period counter sized for `SAMPLE_PERIOD`.

## Structure
- Shared package/include `adc_pkg`: state encoding constants, `ADC_W`=16, minimum-period expression `34*CLK_DIV+2`.
- One sub-module: `sclk_tick_gen`, a `CLK_DIV` counter that emits a one-cycle tick per SCLK half-period, enabled only in SELECT/SHIFT/DESELECT and cleared otherwise.
- FSM, bit counter, shift register and period counter live in `adc_sampler`.

## Test plan
- Reset: assert `rst` for 3 cycles → `adc_cs_n`=1, `adc_sclk`=0, `adc_data`=0, `adc_valid`=0, `busy`=0.
- One-shot: ADC model drives 16'h3081 MSB-first on SCLK falling edges; pulse `start` → exactly 16 SCLK rises while `adc_cs_n`=0, `adc_data`=16'h3081, `adc_valid` one cycle, 137 cycles after start edge.
- Periodic: `enable`=1, `SAMPLE_PERIOD`=200, model returns 16'hFFFF then 16'h0000 → `adc_valid` pulses 200 cycles apart with data FFFF then 0000.
- Busy ignore: second `start` 20 cycles into a conversion → only one conversion, one `adc_valid`.
- Reset mid-shift: assert `rst` after 8 SCLK rises during 16'hA5A5 transfer → `adc_cs_n` high immediately, no `adc_valid`, `adc_data`=0; next `start` yields 16'hA5A5 correctly.
- Enable drop: deassert `enable` in SHIFT → conversion completes with valid pulse, no further conversions.
